// File: rtl/eth_pkg.sv
//------------------------------------------------------------------------------
// Module   : eth_pkg
// Purpose  : Shared receive-path types, byte constants, CRC-32 constants and
//            error-flag bit positions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package eth_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    FRAME    = 2'd2,
    DROP     = 2'd3
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Reflected CRC-32; the register settles to RESIDUE after data plus a good FCS
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam int ERR_GIANT = 0;
  localparam int ERR_RUNT  = 1;
  localparam int ERR_RXER  = 2;
  localparam int ERR_FCS   = 3;

endpackage

`default_nettype wire

// File: rtl/gmii_rx_frame_if.sv
//------------------------------------------------------------------------------
// Module   : gmii_rx_frame_if
// Purpose  : GMII receive inputs plus the framed byte stream and frame status.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gmii_rx_frame_if #(
  parameter int LEN_W = 11
);

  logic             rxDv;
  logic             rxEr;
  logic [7:0]       rxData;
  logic [7:0]       outData;
  logic             outValid;
  logic             outLast;
  logic             frameDone;
  logic             frameGood;
  logic [3:0]       errFlags;
  logic [LEN_W-1:0] frameLen;

  // PHY / source side
  modport master (
    output rxDv, rxEr, rxData,
    input  outData, outValid, outLast, frameDone, frameGood, errFlags, frameLen
  );

  // Framer side
  modport slave (
    input  rxDv, rxEr, rxData,
    output outData, outValid, outLast, frameDone, frameGood, errFlags, frameLen
  );

endinterface

`default_nettype wire

// File: rtl/eth_crc32_byte.sv
//------------------------------------------------------------------------------
// Module   : eth_crc32_byte
// Purpose  : Combinational next-state of a reflected CRC-32 for one byte.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_crc;

  always_comb begin
    w_crc = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC32_POLY) : (w_crc >> 1);
    end
    o_crc = w_crc;
  end

endmodule

`default_nettype wire

// File: rtl/gmii_rx_frame.sv
//------------------------------------------------------------------------------
// Module   : gmii_rx_frame
// Purpose  : GMII receive framer: strips preamble/SFD/FCS, streams frame bytes
//            and reports per-frame status. Define ETH_FCS_CHECK_EN to add the
//            CRC-32 FCS check.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gmii_rx_frame
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int LEN_W           = 11
) (
  input  logic          rxClk,
  input  logic          rstN,
  gmii_rx_frame_if.slave gmii
);

  localparam logic [LEN_W-1:0] C_GIANT_LEN = LEN_W'(MAX_FRAME_BYTES + 1);
  localparam logic [LEN_W-1:0] C_MIN_LEN   = LEN_W'(MIN_FRAME_BYTES);
  localparam logic [LEN_W-1:0] C_HOLD_LEN  = LEN_W'(5);

  rx_state_t        r_state;
  rx_state_t        w_nextState;
  logic [7:0]       r_dly [5];
  logic [LEN_W-1:0] r_len;
  logic             r_rxErSeen;

  logic             w_shift;
  logic             w_sfd;
  logic             w_endFrame;
  logic             w_giant;
  logic             w_emitData;
  logic             w_endValid;
  logic             w_fcsErr;
  logic [3:0]       w_flags;

  always_ff @(posedge rxClk or negedge rstN) begin
    if (!rstN) begin
      r_state <= DROP;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_shift     = 1'b0;
    w_sfd       = 1'b0;
    w_endFrame  = 1'b0;
    w_giant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (gmii.rxDv) begin
          w_nextState = (gmii.rxData == PREAMBLE_BYTE) ? PREAMBLE : DROP;
        end
      end
      PREAMBLE: begin
        if (gmii.rxDv && gmii.rxData == PREAMBLE_BYTE) begin
          w_nextState = PREAMBLE;
        end else if (gmii.rxDv && gmii.rxData == SFD_BYTE) begin
          w_nextState = FRAME;
          w_sfd       = 1'b1;
        end else begin
          w_nextState = DROP;
        end
      end
      FRAME: begin
        // Giant cut-off wins over a coincident end of carrier
        if (r_len == C_GIANT_LEN) begin
          w_giant     = 1'b1;
          w_endFrame  = 1'b1;
          w_nextState = DROP;
        end else if (!gmii.rxDv) begin
          w_endFrame  = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_shift = 1'b1;
        end
      end
      DROP: begin
        if (!gmii.rxDv) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = DROP;
    endcase
  end

  // Five bytes stay in the delay line so the trailing FCS is never emitted
  assign w_emitData = w_shift && (r_len >= C_HOLD_LEN);
  assign w_endValid = w_endFrame && (r_len >= C_HOLD_LEN);

  assign w_flags[ERR_GIANT] = w_giant;
  assign w_flags[ERR_RUNT]  = (r_len < C_MIN_LEN);
  assign w_flags[ERR_RXER]  = r_rxErSeen | gmii.rxEr;
  assign w_flags[ERR_FCS]   = w_fcsErr;

`ifdef ETH_FCS_CHECK_EN
  logic [31:0] r_crc;
  logic [31:0] w_crcNext;

  eth_crc32_byte u_crc (
    .i_crc  (r_crc),
    .i_data (gmii.rxData),
    .o_crc  (w_crcNext)
  );

  always_ff @(posedge rxClk or negedge rstN) begin
    if (!rstN) begin
      r_crc <= CRC32_INIT;
    end else if (w_sfd) begin
      r_crc <= CRC32_INIT;
    end else if (w_shift) begin
      r_crc <= w_crcNext;
    end
  end

  assign w_fcsErr = w_giant | (r_crc != CRC32_RESIDUE);
`else
  assign w_fcsErr = 1'b0;
`endif

  always_ff @(posedge rxClk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 5; i++) begin
        r_dly[i] <= 8'h00;
      end
      r_len          <= '0;
      r_rxErSeen     <= 1'b0;
      gmii.outData   <= 8'h00;
      gmii.outValid  <= 1'b0;
      gmii.outLast   <= 1'b0;
      gmii.frameDone <= 1'b0;
      gmii.frameGood <= 1'b0;
      gmii.errFlags  <= 4'h0;
      gmii.frameLen  <= '0;
    end else begin
      gmii.outValid  <= w_emitData | w_endValid;
      gmii.outLast   <= w_endValid;
      gmii.frameDone <= w_endFrame;
      if (w_emitData || w_endValid) begin
        gmii.outData <= r_dly[4];
      end
      if (w_sfd) begin
        r_len      <= '0;
        r_rxErSeen <= 1'b0;
      end
      if (w_shift) begin
        r_dly[0] <= gmii.rxData;
        for (int i = 1; i < 5; i++) begin
          r_dly[i] <= r_dly[i-1];
        end
        r_len <= r_len + 1'b1;
      end
      if (r_state == FRAME && gmii.rxEr) begin
        r_rxErSeen <= 1'b1;
      end
      if (w_endFrame) begin
        gmii.frameGood <= ~|w_flags;
        gmii.errFlags  <= w_flags;
        gmii.frameLen  <= r_len;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gmii_rx_frame.sv
//------------------------------------------------------------------------------
// Module   : tb_gmii_rx_frame
// Purpose  : Directed self-checking bench for gmii_rx_frame.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gmii_rx_frame;

  logic clk  = 1'b0;
  logic rstN = 1'b1;

  always #4 clk = ~clk;

  gmii_rx_frame_if #(.LEN_W(11)) gmii ();

  gmii_rx_frame #(
    .MIN_FRAME_BYTES (64),
    .MAX_FRAME_BYTES (1518),
    .LEN_W           (11)
  ) dut (
    .rxClk (clk),
    .rstN  (rstN),
    .gmii  (gmii)
  );

  int checkCnt = 0;
  int passCnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor, sampled on the falling edge
  int         cyc = 0;
  logic [7:0] got[$];
  int         lastIdx, lastCnt, lastNoValid, gapCnt, doneCnt, goodCnt, firstCyc;
  bit         inStream;
  logic [3:0] dFlags;
  logic       dGood;
  logic [10:0] dLen;
  int         byte5Cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (gmii.outLast && !gmii.outValid) lastNoValid++;
    if (inStream && !gmii.outValid) gapCnt++;
    if (gmii.outValid) begin
      if (got.size() == 0) firstCyc = cyc;
      if (gmii.outLast) begin
        lastIdx  = got.size();
        lastCnt++;
        inStream = 1'b0;
      end else begin
        inStream = 1'b1;
      end
      got.push_back(gmii.outData);
    end
    if (gmii.frameDone) begin
      doneCnt++;
      dFlags = gmii.errFlags;
      dGood  = gmii.frameGood;
      dLen   = gmii.frameLen;
      if (gmii.frameGood) goodCnt++;
    end
  end

  task automatic clearMon();
    got.delete();
    lastIdx     = -1;
    lastCnt     = 0;
    lastNoValid = 0;
    gapCnt      = 0;
    doneCnt     = 0;
    goodCnt     = 0;
    firstCyc    = -1;
    inStream    = 1'b0;
  endtask

  task automatic drive(input bit dv, input bit er, input logic [7:0] d);
    gmii.rxDv   = dv;
    gmii.rxEr   = er;
    gmii.rxData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Preamble, SFD, nData bytes of pattern i[7:0], optional FCS, one idle cycle
  task automatic sendFrame(input int nData, input int erIdx, input bit withFcs, input bit flip);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < nData; i++) begin
      b   = i[7:0];
      crc = crcByte(crc, b);
      drive(1'b1, i == erIdx, b);
      if (i == 5) byte5Cyc = cyc;
    end
    if (withFcs) begin
      fcs = ~crc;
      if (flip) fcs = fcs ^ 32'h0000FF00;
      for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, fcs[8*k +: 8]);
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  function automatic int dataErrs(input int n, input int period);
    int e;
    int m;
    e = 0;
    m = (got.size() < n) ? got.size() : n;
    for (int i = 0; i < m; i++) if (got[i] !== 8'(i % period)) e++;
    return e + (n - m);
  endfunction

  logic [3:0] expFlip, expShort, expGiant;
  logic       expFlipGood;

  initial begin
`ifdef ETH_FCS_CHECK_EN
    expFlip = 4'b1000; expFlipGood = 1'b0; expShort = 4'b1010; expGiant = 4'b1001;
`else
    expFlip = 4'b0000; expFlipGood = 1'b1; expShort = 4'b0010; expGiant = 4'b0001;
`endif
    gmii.rxDv = 1'b0; gmii.rxEr = 1'b0; gmii.rxData = 8'h00;
    clearMon();
    #1 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outData",   32'(gmii.outData),   0);
    check("rst_outValid",  32'(gmii.outValid),  0);
    check("rst_outLast",   32'(gmii.outLast),   0);
    check("rst_frameDone", 32'(gmii.frameDone), 0);
    check("rst_frameGood", 32'(gmii.frameGood), 0);
    check("rst_errFlags",  32'(gmii.errFlags),  0);
    check("rst_frameLen",  32'(gmii.frameLen),  0);
    rstN = 1'b1;
    idle(3);

    // Legal 64-byte frame
    clearMon();
    sendFrame(60, -1, 1'b1, 1'b0);
    idle(3);
    check("legal_count",   got.size(), 60);
    check("legal_data",    dataErrs(60, 1 << 20), 0);
    check("legal_lastIdx", lastIdx, 59);
    check("legal_lastCnt", lastCnt, 1);
    check("legal_lastNoV", lastNoValid, 0);
    check("legal_gaps",    gapCnt, 0);
    check("legal_latency", firstCyc, byte5Cyc);
    check("legal_done",    doneCnt, 1);
    check("legal_good",    32'(dGood), 1);
    check("legal_flags",   32'(dFlags), 0);
    check("legal_len",     32'(dLen), 64);

    // Corrupted FCS byte
    clearMon();
    sendFrame(60, -1, 1'b1, 1'b1);
    idle(3);
    check("flip_count", got.size(), 60);
    check("flip_flags", 32'(dFlags), 32'(expFlip));
    check("flip_good",  32'(dGood), 32'(expFlipGood));

    // Runt: 40 bytes after SFD
    clearMon();
    sendFrame(36, -1, 1'b1, 1'b0);
    idle(3);
    check("runt_count",   got.size(), 36);
    check("runt_data",    dataErrs(36, 1 << 20), 0);
    check("runt_lastIdx", lastIdx, 35);
    check("runt_flags",   32'(dFlags), 32'b0010);
    check("runt_good",    32'(dGood), 0);
    check("runt_len",     32'(dLen), 40);

    // Fewer than five bytes: status only, no data
    clearMon();
    sendFrame(3, -1, 1'b0, 1'b0);
    idle(3);
    check("short_count", got.size(), 0);
    check("short_done",  doneCnt, 1);
    check("short_len",   32'(dLen), 3);
    check("short_flags", 32'(dFlags), 32'(expShort));

    // Giant: 1600 bytes after SFD
    clearMon();
    sendFrame(1600, -1, 1'b0, 1'b0);
    idle(3);
    check("giant_count",   got.size(), 1515);
    check("giant_data",    dataErrs(1515, 1 << 20), 0);
    check("giant_lastIdx", lastIdx, 1514);
    check("giant_gaps",    gapCnt, 0);
    check("giant_done",    doneCnt, 1);
    check("giant_flags",   32'(dFlags), 32'(expGiant));
    check("giant_len",     32'(dLen), 1519);
    check("giant_good",    32'(dGood), 0);

    // rxEr on payload byte 20
    clearMon();
    sendFrame(60, 20, 1'b1, 1'b0);
    idle(3);
    check("rxer_count", got.size(), 60);
    check("rxer_data",  dataErrs(60, 1 << 20), 0);
    check("rxer_flags", 32'(dFlags), 32'b0100);
    check("rxer_good",  32'(dGood), 0);
    check("rxer_len",   32'(dLen), 64);

    // Broken preamble is dropped silently
    clearMon();
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h12);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'hD5);
    idle(3);
    check("badpre_count", got.size(), 0);
    check("badpre_done",  doneCnt, 0);

    // Reset mid-payload, released while rxDv is still high
    clearMon();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(i));
    check("rstmid_pre_valid", 32'(gmii.outValid), 1);
    rstN = 1'b0;
    #1;
    check("rstmid_valid", 32'(gmii.outValid), 0);
    check("rstmid_data",  32'(gmii.outData), 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    clearMon();
    for (int i = 20; i < 60; i++) drive(1'b1, 1'b0, 8'(i));
    drive(1'b0, 1'b0, 8'h00);
    check("rstmid_count", got.size(), 0);
    check("rstmid_done",  doneCnt, 0);

    // Two legal frames separated by one idle cycle
    clearMon();
    sendFrame(60, -1, 1'b1, 1'b0);
    sendFrame(60, -1, 1'b1, 1'b0);
    idle(3);
    check("b2b_count",   got.size(), 120);
    check("b2b_data",    dataErrs(120, 60), 0);
    check("b2b_done",    doneCnt, 2);
    check("b2b_good",    goodCnt, 2);
    check("b2b_lastCnt", lastCnt, 2);
    check("b2b_len",     32'(dLen), 64);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

`default_nettype wire
